// File: rtl/kalman_filter_1d.sv
`default_nettype none
// ============================================================================
// Module      : kalman_filter_1d
// Description : Scalar fixed-point Kalman filter for a stream of signed 16-bit
//               sensor samples. The gain comes from a 16-step bit-serial
//               restoring divider, so one sample takes 19 cycles.
// Ports       : clk           - system clock, rising edge
//               reset         - synchronous, active-high
//               measurement   - signed raw sample z
//               meas_valid    - sample strobe, honoured only while idle
//               filtered_data - signed estimate x, held between updates
//               filter_done   - one-cycle pulse when filtered_data is new
//               busy          - an estimate is being computed
//               dropped       - sticky: a sample arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
module kalman_filter_1d #(
    parameter logic [15:0] Q      = 16'd16,
    parameter logic [15:0] R      = 16'd256,
    parameter logic [15:0] P_INIT = 16'd256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] measurement,
    input  logic               meas_valid,
    output logic signed [15:0] filtered_data,
    output logic               filter_done,
    output logic               busy,
    output logic               dropped
);

    // A zero measurement noise would let the gain reach 1.0, which does not
    // fit the Q0.16 gain register.
    generate
        if (R == 16'd0) begin : g_bad_r
            $error("kalman_filter_1d: R must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREDICT = 2'd1,
        ST_DIVIDE  = 2'd2,
        ST_UPDATE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic signed [15:0] r_z;
    logic signed [15:0] r_x;
    logic        [15:0] r_p;
    logic        [15:0] r_p_pred;
    logic        [16:0] r_denom;
    logic        [16:0] r_rem;
    logic        [15:0] r_gain;
    logic        [3:0]  r_count;
    logic               r_div_last;
    logic               r_initialized;

    // ---------------- predict ----------------
    logic        [16:0] w_p_sum;
    logic        [15:0] w_p_pred;
    assign w_p_sum  = {1'b0, r_p} + {1'b0, Q};
    assign w_p_pred = w_p_sum[16] ? 16'hFFFF : w_p_sum[15:0];

    // ---------------- restoring divide step ----------------
    // The remainder starts as P_pred (always < D), so each step shifts in a
    // zero from the low half of the dividend P_pred * 2^16.
    logic        [17:0] w_trial;
    logic               w_fits;
    logic        [16:0] w_rem_sub;
    assign w_trial   = {r_rem, 1'b0};
    assign w_fits    = (w_trial >= {1'b0, r_denom});
    assign w_rem_sub = w_trial[16:0] - r_denom;

    // ---------------- update ----------------
    logic signed [16:0] w_err;
    logic signed [33:0] w_prod;
    logic signed [17:0] w_corr;
    logic signed [17:0] w_x_sum;
    logic signed [15:0] w_x_new;
    logic        [16:0] w_one_minus_k;
    logic        [32:0] w_p_prod;
    logic        [15:0] w_p_new;
    logic               w_unused;

    assign w_err  = $signed({r_z[15], r_z}) - $signed({r_x[15], r_x});
    assign w_prod = $signed({18'b0, r_gain}) * $signed({{17{w_err[16]}}, w_err});
    // Dropping the low 16 bits of a two's-complement product floors toward -inf.
    assign w_corr  = w_prod[33:16];
    assign w_x_sum = $signed({{2{r_x[15]}}, r_x}) + w_corr;

    always_comb begin
        w_x_new = w_x_sum[15:0];
        if (w_x_sum > 18'sd32767) begin
            w_x_new = 16'sh7FFF;
        end else if (w_x_sum < -18'sd32768) begin
            w_x_new = 16'sh8000;
        end
    end

    // (1 - K) * P_pred never exceeds P_pred, so bits [31:16] hold the result.
    assign w_one_minus_k = 17'h10000 - {1'b0, r_gain};
    assign w_p_prod      = {16'b0, w_one_minus_k} * {17'b0, r_p_pred};
    assign w_p_new       = w_p_prod[31:16];

    assign w_unused = ^{w_prod[15:0], w_p_prod[32], w_p_prod[15:0]};

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (meas_valid && r_initialized) w_state_next = ST_PREDICT;
            ST_PREDICT: w_state_next = ST_DIVIDE;
            // One extra DIVIDE cycle after the last step lets the final
            // quotient bit settle in r_gain before UPDATE uses it.
            ST_DIVIDE:  if (r_div_last) w_state_next = ST_UPDATE;
            ST_UPDATE:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_z           <= '0;
            r_x           <= '0;
            r_p           <= '0;
            r_p_pred      <= '0;
            r_denom       <= '0;
            r_rem         <= '0;
            r_gain        <= '0;
            r_count       <= '0;
            r_div_last    <= 1'b0;
            r_initialized <= 1'b0;
            filtered_data <= '0;
            filter_done   <= 1'b0;
            dropped       <= 1'b0;
        end else begin
            filter_done <= 1'b0;
            if (meas_valid && (r_state != ST_IDLE)) begin
                dropped <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (meas_valid) begin
                        r_z <= measurement;
                        if (!r_initialized) begin
                            r_x           <= measurement;
                            r_p           <= P_INIT;
                            filtered_data <= measurement;
                            filter_done   <= 1'b1;
                            r_initialized <= 1'b1;
                        end
                    end
                end
                ST_PREDICT: begin
                    r_p_pred   <= w_p_pred;
                    r_denom    <= {1'b0, w_p_pred} + {1'b0, R};
                    r_rem      <= {1'b0, w_p_pred};
                    r_gain     <= '0;
                    r_count    <= 4'd15;
                    r_div_last <= 1'b0;
                end
                ST_DIVIDE: begin
                    if (!r_div_last) begin
                        r_rem  <= w_fits ? w_rem_sub : w_trial[16:0];
                        r_gain <= {r_gain[14:0], w_fits};
                        if (r_count == 4'd0) begin
                            r_div_last <= 1'b1;
                        end else begin
                            r_count <= r_count - 4'd1;
                        end
                    end
                end
                ST_UPDATE: begin
                    r_x           <= w_x_new;
                    r_p           <= w_p_new;
                    filtered_data <= w_x_new;
                    filter_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kalman_filter_1d.sv
`default_nettype none
// ============================================================================
// Module      : tb_kalman_filter_1d
// Description : Self-checking bench for kalman_filter_1d (Q=0, R=256,
//               P_INIT=256). Stimulus pushes expected results into a queue;
//               a negedge monitor compares whenever filter_done is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kalman_filter_1d;

    localparam longint c_q      = 0;
    localparam longint c_r      = 256;
    localparam longint c_p_init = 256;
    localparam int     c_big    = 32'h7FFFFFFF;

    logic               clk;
    logic               reset;
    logic signed [15:0] measurement;
    logic               meas_valid;
    logic signed [15:0] filtered_data;
    logic               filter_done;
    logic               busy;
    logic               dropped;

    kalman_filter_1d #(
        .Q      (16'd0),
        .R      (16'd256),
        .P_INIT (16'd256)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .measurement   (measurement),
        .meas_valid    (meas_valid),
        .filtered_data (filtered_data),
        .filter_done   (filter_done),
        .busy          (busy),
        .dropped       (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint val;
        int     edge_n;
    } exp_t;
    exp_t q[$];

    longint m_x = 0;
    longint m_p = 0;
    bit     m_init = 1'b0;
    int     free_edge = 0;
    int     busy_lo = 1, busy_hi = 0;
    int     drop_edge = c_big;
    int     prev_drop_lo = c_big, prev_drop_hi = 0;
    bit     mon_en = 1'b0;

    // Sample z presented to the edge numbered n.
    task automatic model_issue(input int n, input longint z);
        longint ppred, d, k, e, corr, nx;
        exp_t it;
        if (n < free_edge) begin
            if (drop_edge > n) drop_edge = n;
        end else if (!m_init) begin
            m_x = z; m_p = c_p_init; m_init = 1'b1;
            it.val = z; it.edge_n = n; q.push_back(it);
        end else begin
            ppred = m_p + c_q;
            if (ppred > 65535) ppred = 65535;
            d    = ppred + c_r;
            k    = (ppred * 65536) / d;
            e    = z - m_x;
            corr = (k * e) >>> 16;
            nx   = m_x + corr;
            if (nx > 32767)  nx = 32767;
            if (nx < -32768) nx = -32768;
            m_p = ((65536 - k) * ppred) >> 16;
            m_x = nx;
            it.val = nx; it.edge_n = n + 19; q.push_back(it);
            busy_lo = n; busy_hi = n + 18; free_edge = n + 20;
        end
    endtask

    // Reset sampled at edge n aborts anything not yet delivered.
    task automatic model_reset(input int n);
        exp_t keep[$];
        m_x = 0; m_p = 0; m_init = 1'b0; free_edge = 0;
        if (busy_hi >= n) busy_hi = n - 1;
        if (drop_edge < n) begin
            prev_drop_lo = drop_edge; prev_drop_hi = n - 1;
        end
        drop_edge = c_big;
        foreach (q[i]) if (q[i].edge_n < n) keep.push_back(q[i]);
        q = keep;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            chk("dropped", dropped,
                (cyc >= drop_edge) || (cyc >= prev_drop_lo && cyc <= prev_drop_hi));
            if (q.size() > 0 && q[0].edge_n == cyc) begin
                chk("filter_done_due", filter_done, 1);
                chk("filtered_data", filtered_data, q[0].val);
                void'(q.pop_front());
            end else begin
                chk("filter_done_unexpected", filter_done, 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit v, input int z, input bit rst);
        int n;
        @(posedge clk); #1;
        n           = cyc + 1;
        reset       = rst;
        meas_valid  = v;
        measurement = 16'(z);
        if (rst) model_reset(n);
        else if (v) model_issue(n, z);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; meas_valid = 1'b0; measurement = '0;
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("reset_data", filtered_data, 0);
        chk("reset_done", filter_done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_dropped", dropped, 0);
        mon_en = 1'b1;

        // First sample: one-cycle path
        step(1'b1, 1000, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("first_done", filter_done, 1);
        chk("first_data", filtered_data, 1000);
        chk("first_busy", busy, 0);
        idle(5);

        // K = 0.5, latency 19
        step(1'b1, 2000, 1'b0);
        idle(19);
        chk("latency_not_early", filter_done, 0);
        idle(1);
        chk("k_half_done", filter_done, 1);
        chk("k_half_data", filtered_data, 1500);
        idle(3);

        // Negative correction rounds toward -inf
        step(1'b1, -1500, 1'b0);
        idle(20);
        chk("floor_data", filtered_data, 500);
        idle(3);

        // Sample during busy is dropped, in-flight result unchanged
        step(1'b1, 10, 1'b0);
        idle(4);
        step(1'b1, 7, 1'b0);
        idle(15);
        chk("drop_result", filtered_data, 377);
        chk("drop_sticky", dropped, 1);
        idle(10);
        chk("drop_still_set", dropped, 1);

        // Reset in the middle of DIVIDE
        step(1'b1, 50, 1'b0);
        idle(11);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("abort_data", filtered_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dropped", dropped, 0);
        idle(25);
        step(1'b1, -300, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("post_reset_done", filter_done, 1);
        chk("post_reset_data", filtered_data, -300);
        idle(3);

        // Back-to-back: accept in the filter_done cycle
        step(1'b1, 300, 1'b0);
        idle(19);
        step(1'b1, 384, 1'b0);
        chk("b2b_done_when_sent", filter_done, 1);
        chk("b2b_first_data", filtered_data, 0);
        idle(20);
        chk("b2b_second_done", filter_done, 1);
        chk("b2b_second_data", filtered_data, 127);
        chk("b2b_no_drop", dropped, 0);
        idle(3);

        // Randomized traffic, including drops and occasional resets
        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 24));
            if ($urandom_range(0, 39) == 0) step(1'b0, 0, 1'b1);
            else step(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0);
        end

        idle(30);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
